// File: rtl/snes_port_pkg.sv
// Shared types and constants for the SNES controller-port scheduler.
// Holds the device-mode and serial-protocol state encodings plus the mouse clamp helper.
package snes_port_pkg;

  typedef enum logic [1:0] {
    PM_PAD   = 2'd0,
    PM_MOUSE = 2'd1,
    PM_GUN   = 2'd2,
    PM_NONE  = 2'd3
  } port_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int         PAD_BITS   = 16;
  localparam int         MOUSE_BITS = 32;
  localparam int         MAG_MAX    = 127;
  localparam logic [3:0] MOUSE_SIG  = 4'b0001;

  // Saturate a widened motion sum to +/-MAG_MAX and return it at accumulator width.
  function automatic logic signed [9:0] clamp_mag(input logic signed [11:0] v);
    logic signed [11:0] hi;
    logic signed [11:0] lo;
    logic signed [11:0] r;
    hi = 12'(MAG_MAX);
    lo = -hi;
    if (v > hi) begin
      r = hi;
    end else if (v < lo) begin
      r = lo;
    end else begin
      r = v;
    end
    return r[9:0];
  endfunction

endpackage

// File: rtl/snes_port_ctrl_mouse_accum.sv
// Mouse motion accumulator: packet-toggle detection, sensitivity scaling, clamping,
// snapshot-and-clear on read, and sign/magnitude view of the accumulated motion.
module mouse_accum
  import snes_port_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       pkt_tog,
  input  logic [7:0] dx,
  input  logic [7:0] dy,
  input  logic       dx_sign,
  input  logic       dy_sign,
  input  logic [1:0] btn,
  input  logic       sens_adv,
  input  logic       snap,
  output logic [1:0] sens,
  output logic [1:0] btn_lat,
  output logic       x_dir,
  output logic [6:0] x_mag,
  output logic       y_dir,
  output logic [6:0] y_mag
);

  logic               tog_q_r;
  logic [1:0]         sens_r;
  logic [1:0]         btn_r;
  logic signed [9:0]  acc_x_r;
  logic signed [9:0]  acc_y_r;
  logic               pkt_s;
  logic signed [11:0] dx_sh_s;
  logic signed [11:0] dy_sh_s;
  logic signed [11:0] base_x_s;
  logic signed [11:0] base_y_s;
  logic signed [9:0]  acc_x_nxt_s;
  logic signed [9:0]  acc_y_nxt_s;
  logic signed [9:0]  neg_x_s;
  logic signed [9:0]  neg_y_s;

  // Next accumulator values; a snapshot zeroes the base so a coincident packet survives.
  always_comb begin
    pkt_s       = pkt_tog ^ tog_q_r;
    dx_sh_s     = $signed({{3{dx_sign}}, dx_sign, dx}) <<< sens_r;
    dy_sh_s     = $signed({{3{dy_sign}}, dy_sign, dy}) <<< sens_r;
    base_x_s    = snap ? 12'sd0 : {{2{acc_x_r[9]}}, acc_x_r};
    base_y_s    = snap ? 12'sd0 : {{2{acc_y_r[9]}}, acc_y_r};
    acc_x_nxt_s = clamp_mag(base_x_s + dx_sh_s);
    acc_y_nxt_s = clamp_mag(base_y_s - dy_sh_s);
  end

  // Sign/magnitude view: negative X is left, negative Y (after flip) is up.
  always_comb begin
    neg_x_s = -acc_x_r;
    neg_y_s = -acc_y_r;
    x_dir   = acc_x_r[9];
    y_dir   = acc_y_r[9];
    if (acc_x_r[9]) begin
      x_mag = neg_x_s[6:0];
    end else begin
      x_mag = acc_x_r[6:0];
    end
    if (acc_y_r[9]) begin
      y_mag = neg_y_s[6:0];
    end else begin
      y_mag = acc_y_r[6:0];
    end
  end

  // Packet edge register, sensitivity cycle, button latch and accumulators.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tog_q_r <= 1'b0;
      sens_r  <= 2'd0;
      btn_r   <= 2'd0;
      acc_x_r <= 10'sd0;
      acc_y_r <= 10'sd0;
    end else begin
      tog_q_r <= pkt_tog;
      if (sens_adv) begin
        sens_r <= (sens_r == 2'd2) ? 2'd0 : sens_r + 2'd1;
      end
      if (pkt_s) begin
        btn_r <= btn;
      end
      if (snap || pkt_s) begin
        acc_x_r <= pkt_s ? acc_x_nxt_s : 10'sd0;
        acc_y_r <= pkt_s ? acc_y_nxt_s : 10'sd0;
      end
    end
  end

  assign sens    = sens_r;
  assign btn_lat = btn_r;

endmodule

// File: rtl/snes_port_ctrl.sv
// One SNES controller port: picks pad, mouse, gun or nothing, and runs the
// latch/clock serial protocol towards the CPU joypad logic.
module snes_port_ctrl
  import snes_port_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  MODE,
  input  logic [11:0] JOY,
  input  logic [24:0] MOUSE,
  input  logic        PORT_LATCH,
  input  logic        PORT_CLK,
  output logic [1:0]  PORT_DO,
  output logic        PORT_P6,
  output logic        GUN_LATCH,
  output logic        GUN_CLK,
  input  logic [1:0]  GUN_DO,
  input  logic        GUN_P6,
  output logic [1:0]  SENS
);

  logic                  latch_q_r;
  logic                  clk_q_r;
  state_t                state_r;
  port_mode_t            mode_r;
  logic [MOUSE_BITS-1:0] shift_r;
  logic [5:0]            cnt_r;

  logic                  latch_rise_s;
  logic                  latch_fall_s;
  logic                  clk_rise_s;
  logic                  sens_adv_s;
  logic                  snap_s;
  logic [5:0]            cnt_inc_s;
  logic [5:0]            len_s;
  logic [MOUSE_BITS-1:0] report_s;
  logic [1:0]            btn_s;
  logic                  x_dir_s;
  logic                  y_dir_s;
  logic [6:0]            x_mag_s;
  logic [6:0]            y_mag_s;
  logic                  unused_s;

  assign unused_s = ^{MOUSE[7:6], MOUSE[3:2]};

  mouse_accum u_mouse (
    .CLK      (CLK),
    .RESET    (RESET),
    .pkt_tog  (MOUSE[24]),
    .dx       (MOUSE[15:8]),
    .dy       (MOUSE[23:16]),
    .dx_sign  (MOUSE[4]),
    .dy_sign  (MOUSE[5]),
    .btn      (MOUSE[1:0]),
    .sens_adv (sens_adv_s),
    .snap     (snap_s),
    .sens     (SENS),
    .btn_lat  (btn_s),
    .x_dir    (x_dir_s),
    .x_mag    (x_mag_s),
    .y_dir    (y_dir_s),
    .y_mag    (y_mag_s)
  );

  // Pin edges, live report for the latched mode, and its serial length.
  always_comb begin
    latch_rise_s = PORT_LATCH & ~latch_q_r;
    latch_fall_s = ~PORT_LATCH & latch_q_r;
    clk_rise_s   = PORT_CLK & ~clk_q_r;
    sens_adv_s   = (state_r == LATCH) && (mode_r == PM_MOUSE) && PORT_LATCH && clk_rise_s;
    snap_s       = (state_r == LATCH) && (mode_r == PM_MOUSE) && latch_fall_s;
    cnt_inc_s    = (cnt_r == 6'd63) ? 6'd63 : cnt_r + 6'd1;
    case (mode_r)
      PM_PAD: begin
        report_s = {JOY, 4'b0000, 16'hFFFF};
        len_s    = 6'(PAD_BITS);
      end
      PM_MOUSE: begin
        report_s = {8'h00, btn_s, SENS, MOUSE_SIG, y_dir_s, y_mag_s, x_dir_s, x_mag_s};
        len_s    = 6'(MOUSE_BITS);
      end
      default: begin
        report_s = {MOUSE_BITS{1'b1}};
        len_s    = 6'(PAD_BITS);
      end
    endcase
  end

  // Serial protocol FSM; a latch rise from SHIFT or DONE restarts the read.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      latch_q_r <= 1'b0;
      clk_q_r   <= 1'b0;
      state_r   <= IDLE;
      mode_r    <= PM_PAD;
      shift_r   <= {MOUSE_BITS{1'b0}};
      cnt_r     <= 6'd0;
    end else begin
      latch_q_r <= PORT_LATCH;
      clk_q_r   <= PORT_CLK;
      case (state_r)
        IDLE: begin
          if (latch_rise_s) begin
            state_r <= LATCH;
            mode_r  <= port_mode_t'(MODE);
          end
        end
        LATCH: begin
          shift_r <= report_s;
          cnt_r   <= 6'd0;
          if (latch_fall_s) begin
            state_r <= SHIFT;
          end
        end
        SHIFT, DONE: begin
          if (latch_rise_s) begin
            state_r <= LATCH;
            mode_r  <= port_mode_t'(MODE);
          end else if (clk_rise_s && (mode_r != PM_GUN)) begin
            shift_r <= {shift_r[MOUSE_BITS-2:0], 1'b1};
            cnt_r   <= cnt_inc_s;
            if ((state_r == SHIFT) && (cnt_inc_s == len_s)) begin
              state_r <= DONE;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Registered pin drivers; the gun owns the port pins only in gun mode.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      PORT_DO   <= 2'b11;
      PORT_P6   <= 1'b1;
      GUN_LATCH <= 1'b0;
      GUN_CLK   <= 1'b1;
    end else begin
      case (mode_r)
        PM_GUN: begin
          PORT_DO   <= GUN_DO;
          PORT_P6   <= GUN_P6;
          GUN_LATCH <= PORT_LATCH;
          GUN_CLK   <= PORT_CLK;
        end
        PM_NONE: begin
          PORT_DO   <= 2'b11;
          PORT_P6   <= 1'b1;
          GUN_LATCH <= 1'b0;
          GUN_CLK   <= 1'b1;
        end
        default: begin
          PORT_DO   <= {1'b1, (state_r == DONE) ? 1'b0 : ~shift_r[MOUSE_BITS-1]};
          PORT_P6   <= 1'b1;
          GUN_LATCH <= 1'b0;
          GUN_CLK   <= 1'b1;
        end
      endcase
    end
  end

endmodule
